sprite_fetch_sched: RTL

- Single-port scheduler in front of the sprite register file (6-bit address, 16-bit write data, write enable, combinational 16-bit read).
- Shares the port between two requesters:
  - the CPU bus
  - a per-scanline fetcher that bursts x/y/rot of PacMan and the four ghosts into a shadow buffer for the sprite renderer.
- The fetcher has priority. The CPU gets single-cycle accesses while the fetcher is idle.

---
 rtl/sprite_pkg.sv | 41 ++++
 rtl/sprite_shadow_buf.sv | 55 +++++
 rtl/sprite_fetch_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite register map, the sprite base lookup and the scheduler state encoding.
package sprite_pkg;

    localparam logic [5:0] PACMAN_BASE     = 6'd0;
    localparam logic [5:0] GHOST0_BASE     = 6'd8;
    localparam logic [5:0] GHOST1_BASE     = 6'd14;
    localparam logic [5:0] GHOST2_BASE     = 6'd20;
    localparam logic [5:0] GHOST3_BASE     = 6'd26;

    localparam logic [1:0] FIELD_X         = 2'd0;
    localparam logic [1:0] FIELD_Y         = 2'd1;
    localparam logic [1:0] FIELD_ROT       = 2'd2;

    localparam logic [5:0] FRAME_LOCK_ADDR = 6'd32;
    localparam logic [5:0] DISP_FIRST_ADDR = 6'd48;
    localparam logic [5:0] DISP_LAST_ADDR  = 6'd51;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_FETCH        = 2'd1;
    localparam logic [1:0] ST_PUBLISH      = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        FETCH   = ST_FETCH,
        PUBLISH = ST_PUBLISH
    } state_t;

    function automatic logic [5:0] sprite_base(input logic [2:0] s);
        logic [5:0] b;
        case (s)
            3'd0:    b = PACMAN_BASE;
            3'd1:    b = GHOST0_BASE;
            3'd2:    b = GHOST1_BASE;
            3'd3:    b = GHOST2_BASE;
            3'd4:    b = GHOST3_BASE;
            default: b = 6'd0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sprite_shadow_buf.sv
// Shadow capture of fetched sprite fields plus the atomically published copy.
// Publish copies the whole shadow in one edge so consumers never see a partial set.
module sprite_shadow_buf #(
    parameter int NUM_SPRITES = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [2:0]               cap_sprite,
    input  logic [1:0]               cap_field,
    input  logic [7:0]               cap_data,
    input  logic                     publish,
    output logic [NUM_SPRITES*8-1:0] spr_x,
    output logic [NUM_SPRITES*8-1:0] spr_y,
    output logic [NUM_SPRITES*8-1:0] spr_rot,
    output logic                     spr_valid
);
    import sprite_pkg::*;

    logic [NUM_SPRITES*8-1:0] sh_x;
    logic [NUM_SPRITES*8-1:0] sh_y;
    logic [NUM_SPRITES*8-1:0] sh_rot;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x   <= '0;
            sh_y   <= '0;
            sh_rot <= '0;
        end else if (cap_en) begin
            case (cap_field)
                FIELD_X:   sh_x[{cap_sprite, 3'b000} +: 8]   <= cap_data;
                FIELD_Y:   sh_y[{cap_sprite, 3'b000} +: 8]   <= cap_data;
                FIELD_ROT: sh_rot[{cap_sprite, 3'b000} +: 8] <= cap_data;
                default:   sh_x <= sh_x;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spr_x     <= '0;
            spr_y     <= '0;
            spr_rot   <= '0;
            spr_valid <= 1'b0;
        end else begin
            spr_valid <= publish;
            if (publish) begin
                spr_x   <= sh_x;
                spr_y   <= sh_y;
                spr_rot <= sh_rot;
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_sched.sv
// Sprite register-file port scheduler: per-line fetch burst has priority, CPU gets single-cycle slots when idle.
// Optional SPR_FETCH_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module sprite_fetch_sched #(
    parameter int NUM_SPRITES = 5,
    parameter int FIELDS      = 3,
    parameter int AW          = 6,
    parameter int DW          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     line_start,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [DW-1:0]            cpu_wdata,
    output logic                     cpu_ack,
    output logic [DW-1:0]            cpu_rdata,
    output logic [AW-1:0]            reg_addr,
    output logic [DW-1:0]            reg_in,
    output logic                     reg_we,
    input  logic [DW-1:0]            reg_out,
    output logic [NUM_SPRITES*8-1:0] spr_x,
    output logic [NUM_SPRITES*8-1:0] spr_y,
    output logic [NUM_SPRITES*8-1:0] spr_rot,
    output logic                     spr_valid,
    output logic                     busy,
    output logic                     overrun
`ifdef SPR_FETCH_OVERRUN_CNT_EN
    ,
    output logic [7:0]               overrun_cnt
`endif
);
    import sprite_pkg::*;

    state_t     state;
    logic [2:0] s_idx;
    logic [1:0] f_idx;
    logic       grant;

    assign busy = (state != IDLE);

    // A held cpu_req is not re-granted in its own ack cycle.
    assign grant = (state == IDLE) && !line_start && cpu_req && !cpu_ack;

    always_comb begin
        reg_addr = '0;
        reg_we   = 1'b0;
        reg_in   = '0;
        if (state == FETCH) begin
            reg_addr = AW'(sprite_base(s_idx) + {4'd0, f_idx});
        end else if (grant) begin
            reg_addr = cpu_addr;
            reg_we   = cpu_we;
            reg_in   = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_idx <= 3'd0;
            f_idx <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_start) begin
                        state <= FETCH;
                        s_idx <= 3'd0;
                        f_idx <= 2'd0;
                    end
                end
                FETCH: begin
                    if (f_idx == 2'(FIELDS - 1)) begin
                        f_idx <= 2'd0;
                        if (s_idx == 3'(NUM_SPRITES - 1)) begin
                            s_idx <= 3'd0;
                            state <= PUBLISH;
                        end else begin
                            s_idx <= s_idx + 3'd1;
                        end
                    end else begin
                        f_idx <= f_idx + 2'd1;
                    end
                end
                PUBLISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            overrun   <= 1'b0;
        end else begin
            cpu_ack   <= grant;
            cpu_rdata <= (grant && !cpu_we) ? reg_out : '0;
            if (line_start && busy) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SPR_FETCH_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= 8'd0;
        end else if (line_start && busy && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

    sprite_shadow_buf #(
        .NUM_SPRITES (NUM_SPRITES)
    ) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .cap_en     (state == FETCH),
        .cap_sprite (s_idx),
        .cap_field  (f_idx),
        .cap_data   (reg_out[7:0]),
        .publish    (state == PUBLISH),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_rot    (spr_rot),
        .spr_valid  (spr_valid)
    );

endmodule
